// File: rtl/race_controller.sv
// Game sequencer: menu -> countdown -> race -> winner, with player-block flush between rounds.
// Optional race inactivity abort is enabled by defining RACE_IDLE_TIMEOUT_EN.
//
// state | meaning
// FLUSH | players_reset high for 2 cycles, screen 10
// MENU  | screen 00, wait for MIN_PLAYERS ready
// COUNT | screen 11, countdown 3,2,1 of STEP_CYCLES each
// RACE  | screen 01, first ready player at the finish wins
// WIN   | screen 10, winner held for WIN_CYCLES
module race_controller #(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_POS     = 16,
    parameter int MIN_PLAYERS = 2,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int WIN_CYCLES  = 250_000_000,
    parameter int IDLE_CYCLES = 500_000_000,
    localparam int PW = $clog2(MAX_POS),
    localparam int IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PLAYERS-1:0]    ready_to_play,
    input  logic [NUM_PLAYERS*PW-1:0] cur_pos_bus,
    input  logic [NUM_PLAYERS-1:0]    activity,
    output logic [1:0]                current_screen,
    output logic [1:0]                countdown_val,
    output logic [IW-1:0]             winner_id,
    output logic                      winner_valid,
    output logic                      players_reset
);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int CW = $clog2(NUM_PLAYERS + 1);

    typedef enum logic [2:0] {S_FLUSH, S_MENU, S_COUNT, S_RACE, S_WIN} state_t;

    state_t          state_q, state_d;
    logic            flush_cnt_q, flush_cnt_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d;
    logic [1:0]      countdown_q, countdown_d;
    logic [IW-1:0]   winner_id_q, winner_id_d;
    logic            winner_valid_q, winner_valid_d;
    logic [1:0]      screen_q, screen_d;
    logic            players_reset_q, players_reset_d;

    logic [CW-1:0]   ready_cnt;
    logic            finish_found;
    logic [IW-1:0]   finish_idx;

`ifdef RACE_IDLE_TIMEOUT_EN
    localparam int DW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    logic [DW-1:0]   idle_cnt_q, idle_cnt_d;
`else
    logic            unused_cfg;
    assign unused_cfg = ^{activity, IDLE_CYCLES[0]};
`endif

    // Descending scan so the lowest-index finisher is the one left standing.
    always_comb begin
        ready_cnt    = '0;
        finish_found = 1'b0;
        finish_idx   = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            ready_cnt = ready_cnt + CW'(ready_to_play[i]);
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (ready_to_play[i] && (cur_pos_bus[i*PW +: PW] >= PW'(MAX_POS - 1))) begin
                finish_found = 1'b1;
                finish_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        step_cnt_d     = step_cnt_q;
        win_cnt_d      = win_cnt_q;
        countdown_d    = countdown_q;
        winner_id_d    = winner_id_q;
        winner_valid_d = winner_valid_q;
`ifdef RACE_IDLE_TIMEOUT_EN
        idle_cnt_d     = idle_cnt_q;
`endif
        case (state_q)
            S_FLUSH: begin
                if (flush_cnt_q) state_d = S_MENU;
                else             flush_cnt_d = 1'b1;
            end
            S_MENU: begin
                if (int'(ready_cnt) >= MIN_PLAYERS) begin
                    state_d     = S_COUNT;
                    countdown_d = 2'd3;
                    step_cnt_d  = '0;
                end
            end
            S_COUNT: begin
                if (step_cnt_q == SW'(STEP_CYCLES - 1)) begin
                    step_cnt_d = '0;
                    if (countdown_q == 2'd1) begin
                        state_d     = S_RACE;
                        countdown_d = 2'd0;
`ifdef RACE_IDLE_TIMEOUT_EN
                        idle_cnt_d  = '0;
`endif
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + SW'(1);
                end
            end
            S_RACE: begin
                if (finish_found) begin
                    state_d        = S_WIN;
                    winner_id_d    = finish_idx;
                    winner_valid_d = 1'b1;
                    win_cnt_d      = '0;
                end
`ifdef RACE_IDLE_TIMEOUT_EN
                else if (|activity) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == DW'(IDLE_CYCLES - 1)) begin
                    state_d        = S_FLUSH;
                    flush_cnt_d    = 1'b0;
                    winner_valid_d = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + DW'(1);
                end
`endif
            end
            S_WIN: begin
                if (win_cnt_q == WW'(WIN_CYCLES - 1)) begin
                    state_d        = S_FLUSH;
                    flush_cnt_d    = 1'b0;
                    winner_valid_d = 1'b0;
                end else begin
                    win_cnt_d = win_cnt_q + WW'(1);
                end
            end
            default: begin
                state_d     = S_FLUSH;
                flush_cnt_d = 1'b0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        case (state_d)
            S_MENU:  screen_d = 2'b00;
            S_RACE:  screen_d = 2'b01;
            S_COUNT: screen_d = 2'b11;
            default: screen_d = 2'b10;
        endcase
        players_reset_d = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FLUSH;
            flush_cnt_q     <= 1'b0;
            step_cnt_q      <= '0;
            win_cnt_q       <= '0;
            countdown_q     <= 2'd0;
            winner_id_q     <= '0;
            winner_valid_q  <= 1'b0;
            screen_q        <= 2'b10;
            players_reset_q <= 1'b1;
`ifdef RACE_IDLE_TIMEOUT_EN
            idle_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            step_cnt_q      <= step_cnt_d;
            win_cnt_q       <= win_cnt_d;
            countdown_q     <= countdown_d;
            winner_id_q     <= winner_id_d;
            winner_valid_q  <= winner_valid_d;
            screen_q        <= screen_d;
            players_reset_q <= players_reset_d;
`ifdef RACE_IDLE_TIMEOUT_EN
            idle_cnt_q      <= idle_cnt_d;
`endif
        end
    end

    assign current_screen = screen_q;
    assign countdown_val  = countdown_q;
    assign winner_id      = winner_id_q;
    assign winner_valid   = winner_valid_q;
    assign players_reset  = players_reset_q;
endmodule
